// File: rtl/spi_ram_pkg.sv
// Shared types and constants for the SPI SRAM streaming controller.
// Fast-read support is selected with the SPI_FAST_READ_EN macro.
package spi_ram_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_ADDR,
    ST_DUMMY,
    ST_DATA,
    ST_STALL
  } state_t;

  localparam logic [7:0] CMD_READ      = 8'h03;
  localparam logic [7:0] CMD_WRITE     = 8'h02;
  localparam logic [7:0] CMD_FAST_READ = 8'h0B;
  localparam int         DUMMY_CYCLES  = 8;

endpackage

// File: rtl/spi_ram_stream_controller_shifter.sv
// 8-bit MSB-first shift register with parallel load and a last-bit flag.
// done is high while the bit counter sits on the 8th bit of a byte.
module spi_byte_shifter (
  input  logic       clk,
  input  logic       rstn,
  input  logic       load,
  input  logic [7:0] load_data,
  input  logic       shift,
  input  logic       sin,
  output logic [7:0] data,
  output logic       done
);

  logic [2:0] bit_cnt;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      data    <= '0;
      bit_cnt <= '0;
    end else if (load) begin
      data    <= load_data;
      bit_cnt <= '0;
    end else if (shift) begin
      data    <= {data[6:0], sin};
      bit_cnt <= bit_cnt + 1'b1;
    end
  end

  assign done = (bit_cnt == 3'd7);

endmodule

// File: rtl/spi_ram_stream_controller.sv
// SPI SRAM burst controller with byte streaming and write flow control.
// Define SPI_FAST_READ_EN to issue 0x0B reads with an 8-cycle dummy phase.
module spi_ram_stream_controller
  import spi_ram_pkg::*;
#(
  parameter int ADDR_BITS = 24,
  parameter int LEN_BITS  = 8
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 spi_miso,
  output logic                 spi_select,
  output logic                 spi_clk_out,
  output logic                 spi_mosi,
  input  logic [ADDR_BITS-1:0] addr_in,
  input  logic [LEN_BITS-1:0]  len_in,
  input  logic                 start_read,
  input  logic                 start_write,
  input  logic [7:0]           wr_data,
  input  logic                 wr_valid,
  output logic                 wr_ready,
  output logic [7:0]           rd_data,
  output logic                 rd_valid,
  output logic                 busy
);

  localparam int PH_W = $clog2(ADDR_BITS > 8 ? ADDR_BITS : 8);

`ifdef SPI_FAST_READ_EN
  localparam logic [7:0] RD_CMD  = CMD_FAST_READ;
  localparam state_t     RD_NEXT = ST_DUMMY;
`else
  localparam logic [7:0] RD_CMD  = CMD_READ;
  localparam state_t     RD_NEXT = ST_DATA;
`endif

  state_t                state, state_n;
  logic                  is_wr;
  logic [ADDR_BITS-1:0]  addr_sr;
  logic [LEN_BITS-1:0]   byte_cnt;
  logic [PH_W-1:0]       phase_cnt;
  logic                  miso_q;

  logic                  take_start;
  logic                  tx_load, tx_shift, tx_done;
  logic [7:0]            tx_ld_data, tx_data;
  logic                  rx_shift, rx_done;
  logic [7:0]            rx_data;
  logic                  addr_adv, phase_clr, cnt_dec;
  logic                  sck_en, wr_rdy;

  always_comb begin
    state_n    = state;
    take_start = 1'b0;
    tx_load    = 1'b0;
    tx_ld_data = '0;
    addr_adv   = 1'b0;
    phase_clr  = 1'b0;
    cnt_dec    = 1'b0;
    wr_rdy     = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (start_write || start_read) begin
          take_start = 1'b1;
          state_n    = ST_CMD;
          tx_load    = 1'b1;
          tx_ld_data = start_write ? CMD_WRITE : RD_CMD;
        end
      end
      ST_CMD: begin
        if (phase_cnt == PH_W'(7)) begin
          state_n    = ST_ADDR;
          phase_clr  = 1'b1;
          tx_load    = 1'b1;
          tx_ld_data = addr_sr[ADDR_BITS-1 -: 8];
          addr_adv   = 1'b1;
        end
      end
      ST_ADDR: begin
        if (phase_cnt == PH_W'(ADDR_BITS-1)) begin
          phase_clr = 1'b1;
          if (is_wr) begin
            wr_rdy = 1'b1;
            if (wr_valid) begin
              state_n    = ST_DATA;
              tx_load    = 1'b1;
              tx_ld_data = wr_data;
            end else begin
              state_n = ST_STALL;
            end
          end else begin
            tx_load = 1'b1;
            state_n = RD_NEXT;
          end
        end else if (tx_done) begin
          tx_load    = 1'b1;
          tx_ld_data = addr_sr[ADDR_BITS-1 -: 8];
          addr_adv   = 1'b1;
        end
      end
      ST_DUMMY: begin
        if (phase_cnt == PH_W'(DUMMY_CYCLES-1))
          state_n = ST_DATA;
      end
      ST_DATA: begin
        if (tx_done) begin
          if (byte_cnt == '0) begin
            state_n = ST_IDLE;
          end else begin
            cnt_dec = 1'b1;
            if (is_wr) begin
              wr_rdy = 1'b1;
              if (wr_valid) begin
                tx_load    = 1'b1;
                tx_ld_data = wr_data;
              end else begin
                state_n = ST_STALL;
              end
            end
          end
        end
      end
      ST_STALL: begin
        wr_rdy = 1'b1;
        if (wr_valid) begin
          state_n    = ST_DATA;
          tx_load    = 1'b1;
          tx_ld_data = wr_data;
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  assign sck_en   = (state == ST_CMD) || (state == ST_ADDR) ||
                    (state == ST_DUMMY) || (state == ST_DATA);
  // Hold the current MOSI bit when entering a stall.
  assign tx_shift = sck_en && !(wr_rdy && !wr_valid);
  assign rx_shift = (state == ST_DATA) && !is_wr;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state     <= ST_IDLE;
      is_wr     <= 1'b0;
      addr_sr   <= '0;
      byte_cnt  <= '0;
      phase_cnt <= '0;
      rd_valid  <= 1'b0;
      rd_data   <= '0;
    end else begin
      state    <= state_n;
      rd_valid <= rx_shift && rx_done;
      if (rx_shift && rx_done)
        rd_data <= {rx_data[6:0], miso_q};
      if (take_start) begin
        is_wr    <= start_write;
        addr_sr  <= addr_in;
        byte_cnt <= len_in;
      end else begin
        if (addr_adv) addr_sr  <= addr_sr << 8;
        if (cnt_dec)  byte_cnt <= byte_cnt - 1'b1;
      end
      if (phase_clr || take_start)
        phase_cnt <= '0;
      else if (sck_en && state != ST_DATA)
        phase_cnt <= phase_cnt + 1'b1;
    end
  end

  // MISO is captured on SCK rising, i.e. the falling clk edge.
  always_ff @(negedge clk) begin
    if (!rstn) miso_q <= 1'b0;
    else       miso_q <= spi_miso;
  end

  spi_byte_shifter u_tx (
    .clk      (clk),
    .rstn     (rstn),
    .load     (tx_load),
    .load_data(tx_ld_data),
    .shift    (tx_shift),
    .sin      (1'b0),
    .data     (tx_data),
    .done     (tx_done)
  );

  spi_byte_shifter u_rx (
    .clk      (clk),
    .rstn     (rstn),
    .load     (take_start),
    .load_data(8'h00),
    .shift    (rx_shift),
    .sin      (miso_q),
    .data     (rx_data),
    .done     (rx_done)
  );

  assign busy        = (state != ST_IDLE);
  assign spi_select  = ~busy;
  assign spi_mosi    = busy & tx_data[7];
  assign spi_clk_out = sck_en & ~clk;
  assign wr_ready    = wr_rdy;

endmodule

// File: tb/tb_spi_ram_stream_controller.sv
// Directed bench for spi_ram_stream_controller with an SPI SRAM model.
// Honours SPI_FAST_READ_EN to expect the 0x0B read sequence.
module tb_spi_ram_stream_controller;

`ifdef SPI_FAST_READ_EN
  localparam bit FAST = 1'b1;
`else
  localparam bit FAST = 1'b0;
`endif
  localparam logic [7:0] RDC = FAST ? 8'h0B : 8'h03;

  logic        clk = 1'b0;
  logic        rstn;
  logic        spi_miso = 1'b0;
  logic        spi_select, spi_clk_out, spi_mosi;
  logic [23:0] addr_in;
  logic [7:0]  len_in;
  logic        start_read, start_write;
  logic [7:0]  wr_data;
  logic        wr_valid, wr_ready;
  logic [7:0]  rd_data;
  logic        rd_valid, busy;

  spi_ram_stream_controller dut (
    .clk        (clk),
    .rstn       (rstn),
    .spi_miso   (spi_miso),
    .spi_select (spi_select),
    .spi_clk_out(spi_clk_out),
    .spi_mosi   (spi_mosi),
    .addr_in    (addr_in),
    .len_in     (len_in),
    .start_read (start_read),
    .start_write(start_write),
    .wr_data    (wr_data),
    .wr_valid   (wr_valid),
    .wr_ready   (wr_ready),
    .rd_data    (rd_data),
    .rd_valid   (rd_valid),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // SRAM contents and serial slave
  logic [7:0] mem [256];
  logic [7:0] sh;
  int         nbits;
  logic [7:0] mosi_bytes[$];
  int         rstart, rk;
  logic [23:0] saddr;
  logic [7:0] rbyte;

  always @(negedge spi_select) begin
    nbits = 0;
    mosi_bytes.delete();
  end

  always @(posedge spi_clk_out) begin
    if (!spi_select) begin
      sh = {sh[6:0], spi_mosi};
      nbits++;
      if (nbits % 8 == 0) mosi_bytes.push_back(sh);
    end
  end

  always @(negedge spi_clk_out) begin
    if (!spi_select && mosi_bytes.size() >= 4) begin
      rstart = (mosi_bytes[0] == 8'h0B) ? 40 : 32;
      if (nbits >= rstart) begin
        rk    = nbits - rstart;
        saddr = {mosi_bytes[1], mosi_bytes[2], mosi_bytes[3]};
        rbyte = mem[8'(saddr + 24'(rk / 8))];
        spi_miso = rbyte[7 - (rk % 8)];
      end
    end
  end

  // Expected read stream and per-cycle compare
  logic [7:0] exp_rd[$];
  logic [7:0] exp_b;
  int         rd_cnt;
  logic [7:0] last_rd;

  always @(negedge clk) begin
    if (rstn) begin
      check("cs_vs_busy", spi_select, !busy);
      if (rd_valid) begin
        rd_cnt++;
        last_rd = rd_data;
        if (exp_rd.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL rd_unexpected: got strobe data %0h expected none",
                   rd_data);
        end else begin
          exp_b = exp_rd.pop_front();
          check("rd_data", rd_data, exp_b);
          check("rd_busy", busy, exp_rd.size() != 0);
        end
      end
    end
  end

  logic [7:0] wr_src[$];
  int         last_busy;

  task automatic run_xfer(input bit wr, input bit both, input logic [23:0] a,
                          input int len, input int stall_n, input bit poke);
    int cyc, busy_cyc, first_rd, idx, hs, stall_left, base;
    logic [7:0] hdr[$];
    base = 32 + 8 * (len + 1) + ((FAST && !wr) ? 8 : 0);
    hdr = {wr ? 8'h02 : RDC, a[23:16], a[15:8], a[7:0]};
    if (FAST && !wr) hdr.push_back(8'h00);
    if (!wr)
      for (int i = 0; i <= len; i++) exp_rd.push_back(mem[8'(a + 24'(i))]);
    rd_cnt = 0; stall_left = stall_n; idx = 0; hs = 0;
    first_rd = -1; busy_cyc = 0; cyc = 1;
    addr_in = a; len_in = 8'(len);
    start_write = wr; start_read = !wr || both; wr_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    start_write = 1'b0; start_read = 1'b0;
    forever begin
      if (rd_valid && first_rd < 0) first_rd = cyc;
      if (!busy) break;
      if (cyc > 6000) begin
        check("timeout", cyc, 0);
        break;
      end
      busy_cyc++;
      start_read = poke && (cyc == 10);
      if (wr) begin
        if (wr_ready && idx == 1 && stall_left > 0) begin
          wr_valid = 1'b0;
          stall_left--;
        end else begin
          wr_valid = (idx <= len);
          if (idx <= len) wr_data = wr_src[idx];
          if (wr_valid && wr_ready) begin
            hs++;
            idx++;
          end
        end
      end
      @(negedge clk);
      cyc++;
    end
    wr_valid = 1'b0; start_read = 1'b0;
    last_busy = busy_cyc;
    @(negedge clk);
    check("idle_after", busy, 0);
    check("busy_cycles", busy_cyc, base + stall_n);
    check("sck_pulses", nbits, base);
    check("mosi_bytes", mosi_bytes.size(), hdr.size() + len + 1);
    for (int i = 0; i < hdr.size(); i++)
      if (i < mosi_bytes.size()) check("mosi_hdr", mosi_bytes[i], hdr[i]);
    if (wr) begin
      check("wr_hs", hs, len + 1);
      for (int i = 0; i <= len; i++)
        if (hdr.size() + i < mosi_bytes.size())
          check("wr_byte", mosi_bytes[hdr.size() + i], wr_src[i]);
    end else begin
      check("rd_strobes", rd_cnt, len + 1);
      check("rd_latency", first_rd, FAST ? 49 : 41);
    end
    check("rd_pending", exp_rd.size(), 0);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'(i * 37 + 11);
    mem[8'h34] = 8'hA5;
    rstn = 1'b0; addr_in = '0; len_in = '0;
    start_read = 1'b0; start_write = 1'b0; wr_data = '0; wr_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_select", spi_select, 1);
    check("rst_sck", spi_clk_out, 0);
    check("rst_mosi", spi_mosi, 0);
    check("rst_busy", busy, 0);
    check("rst_wr_ready", wr_ready, 0);
    check("rst_rd_valid", rd_valid, 0);
    check("rst_rd_data", rd_data, 0);
    rstn = 1'b1;
    @(negedge clk);

    run_xfer(1'b0, 1'b0, 24'h001234, 0, 0, 1'b0);
    check("t1_sck", nbits, FAST ? 48 : 40);
    check("t1_rd", last_rd, 8'hA5);

    wr_src = {8'hDE, 8'hAD, 8'hBE, 8'hEF};
    run_xfer(1'b1, 1'b0, 24'h000100, 3, 0, 1'b0);
    check("t2_sck", nbits, 64);

    wr_src = {8'h11, 8'h22};
    run_xfer(1'b1, 1'b0, 24'h000200, 1, 6, 1'b0);
    check("t3_gated", (last_busy - nbits) >= 5, 1);

    addr_in = 24'h001234; len_in = 8'h00; start_read = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start_read = 1'b0;
    repeat (14) @(negedge clk);
    check("t4_busy_pre", busy, 1);
    rstn = 1'b0;
    @(negedge clk);
    check("t4_select", spi_select, 1);
    check("t4_busy", busy, 0);
    rstn = 1'b1;
    @(negedge clk);
    run_xfer(1'b0, 1'b0, 24'h001234, 0, 0, 1'b0);
    check("t4_rd", last_rd, 8'hA5);

    run_xfer(1'b0, 1'b0, 24'h000010, 1, 0, 1'b1);

    wr_src = {8'h5A};
    run_xfer(1'b1, 1'b1, 24'h000300, 0, 0, 1'b0);
    check("t5_cmd", mosi_bytes.size() > 0 ? mosi_bytes[0] : 8'hxx, 8'h02);

    run_xfer(1'b0, 1'b0, 24'h0000F0, 255, 0, 1'b0);
    check("t5_strobes", rd_cnt, 256);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
